interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Prioritising interrupt controller for the RAT MCU. Collects up to 8 peripheral IRQ lines,
//  latches them as pending, masks them and drives the single INT input of the control unit.
//  Handshakes with the control unit's interrupt cycle and exposes mask/pending/ID/EOI
//  registers on the IO port bus (IN/OUT instructions). One interrupt in service at a time.
// PARAMETERS
//  NUM_SRC    8      number of IRQ sources, 1..8
//  BASE_ADDR  8'h30  PORT_ID of register 0; registers occupy BASE_ADDR..BASE_ADDR+3
// PORTS
//  CLK       in   1        system clock, all logic on posedge
//  RESET_N   in   1        asynchronous, active-low reset
//  IRQ       in   NUM_SRC  raw peripheral requests, asynchronous, active-high
//  INT_ACK   in   1        1-cycle pulse from control unit interrupt cycle (FLG_SHAD_LD)
//  PORT_ID   in   8        IO address
//  OUT_PORT  in   8        IO write data
//  IO_STRB   in   1        IO write strobe
//  INT       out  1        interrupt request to control unit, registered
//  IN_DATA   out  8        IO read data, combinational from PORT_ID
//  IN_HIT    out  1        PORT_ID addresses this block; steers CPU IN mux
// BEHAVIOUR
//  Reset: INT=0, MASK=0, PENDING=0, ACTIVE_ID=0, state IDLE. IN_DATA/IN_HIT follow PORT_ID.
//  Input path: 2-flop sync per IRQ bit, then rising-edge detect. A rising edge sets PENDING[i]
//   on the 3rd posedge after IRQ rises (when setup is met).
//  Registers (offset from BASE_ADDR):
//   +0 MASK     R/W  1 = source enabled; bits >= NUM_SRC read 0, ignore writes
//   +1 PENDING  R, write-1-to-clear; set and clear of the same bit in one cycle: set wins
//   +2 ID/EOI   read {5'b0, ACTIVE_ID}; any write = end-of-interrupt
//   +3          reserved, reads 0 (see CONFIGURATION)
//  Winner = lowest index i with PENDING[i] & MASK[i] (index 0 highest priority).
//  FSM states, from the package:
//   IDLE:    if any (PENDING & MASK) -> REQ; INT=1 from the next cycle.
//   REQ:     INT=1. INT_ACK -> ACTIVE_ID := winner, clear PENDING[winner], -> SERVICE, INT=0
//            next cycle. If (PENDING & MASK)==0 with no ACK -> IDLE, INT=0.
//            ACK in the same cycle as the mask/pending drop: ACK wins, using the winner
//            computed that cycle.
//   SERVICE: INT=0. New edges keep latching. EOI write -> IDLE. INT may re-assert 1 cycle
//            after returning to IDLE if work is pending.
//  INT_ACK in IDLE or SERVICE: ignored. EOI in IDLE or REQ: ignored.
//  Winner changes in REQ (higher priority arrives): ID is resolved at ACK, not at request.
//  RESET_N low mid-operation: everything returns to reset values immediately (async).
//  Sync flops also clear on reset.
//  INT gating by the I flag is done outside this block.
// CONFIGURATION
//  INT_CTRL_LEVEL_TRIG_EN defined: offset +3 = TRIG R/W register, reset 0. TRIG[i]=1 makes
//   source i level-sensitive: PENDING[i] mirrors synchronised IRQ[i]; W1C and ACK do not
//   clear it. A level still high after EOI re-requests.
//  Not defined: all sources edge-triggered; +3 reads 0, writes ignored; no TRIG flops.
// STRUCTURE
//  Package int_ctrl_pkg:
//   - state typedef enum {IDLE, REQ, SERVICE}
//   - offset constants OFS_MASK=0, OFS_PEND=1, OFS_ID=2, OFS_TRIG=3
//   - function prio_enc(8-bit) returning a 3-bit index
//  Sub-module irq_sync (parameter W): 2-flop synchroniser plus rising-edge detector.
//   Outputs sync_level[W] and rise[W].
// TESTING
//  1. MASK=8'h04, pulse IRQ[2] 1 cycle -> PENDING=8'h04 on 3rd edge, INT=1 the next edge;
//     ACK -> ID reads 2, PENDING=0, INT=0.
//  2. MASK=8'hFF, IRQ[5] and IRQ[1] rise together -> ACK yields ID=1, PENDING=8'h20;
//     EOI -> INT=1 again; 2nd ACK -> ID=5.
//  3. IRQ[3] pending, MASK=0 -> INT stays 0; write MASK=8'h08 -> INT=1 one cycle after IDLE
//     sees it; write MASK=0 in REQ -> INT=0, state IDLE.
//  4. PENDING=8'h01 set; W1C write 8'h01 in the same cycle as a new IRQ[0] edge -> PENDING
//     stays 8'h01.
//  5. In SERVICE, IRQ[0] edge -> PENDING[0]=1, INT held 0 until EOI; extra ACK pulse in
//     SERVICE -> no change.
//  6. RESET_N low while in REQ with INT=1 -> INT=0, MASK=0 at once. With
//     INT_CTRL_LEVEL_TRIG_EN: TRIG=8'h01, hold IRQ[0] high, ACK+EOI -> INT re-asserts.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types, register offsets and priority encoder for interrupt_controller
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] OFS_MASK = 2'd0;
    localparam logic [1:0] OFS_PEND = 2'd1;
    localparam logic [1:0] OFS_ID   = 2'd2;
    localparam logic [1:0] OFS_TRIG = 2'd3;

    // Lowest set bit wins; an all-zero vector yields index 0.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        prio_enc = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) prio_enc = 3'(i);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: 2-flop synchroniser plus rising-edge detector per bit
//   clk, rst_n         clock, async active-low reset
//   d_i[W]             asynchronous inputs
//   sync_level[W]      synchronised level
//   rise[W]            one-cycle pulse on a synchronised 0->1 transition
module irq_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sync_level,
    output logic [W-1:0] rise
);
    logic [W-1:0] meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end

    assign sync_level = sync_q;
    assign rise       = sync_q & ~prev_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritising 8-source interrupt controller for the RAT MCU
//   CLK, RESET_N        clock, async active-low reset
//   IRQ[NUM_SRC]        raw asynchronous peripheral requests
//   INT_ACK             interrupt-cycle pulse from the control unit
//   PORT_ID, OUT_PORT, IO_STRB   IO bus write side
//   INT                 registered request to the control unit
//   IN_DATA, IN_HIT     combinational IO read data and address hit
//   Registers at BASE_ADDR+0 MASK, +1 PENDING (W1C), +2 ID/EOI, +3 TRIG or reserved.
//   Define INT_CTRL_LEVEL_TRIG_EN to build the per-source level-trigger (TRIG) register.
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h30
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               INT_ACK,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic               INT,
    output logic [7:0]         IN_DATA,
    output logic               IN_HIT
);
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [NUM_SRC-1:0] lvl_n, rise_n;
    logic [7:0]         lvl, rise, pm, trig, ack_clr, w1c;
    logic [7:0]         mask_q, mask_d, pend_q, pend_d, ofs;
    logic [2:0]         id_q, id_d, win;
    state_t             state_q, state_d;
    logic               hit, wr, take, eoi;
    logic [1:0]         sel;

    irq_sync #(.W(NUM_SRC)) u_sync (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .d_i        (IRQ),
        .sync_level (lvl_n),
        .rise       (rise_n)
    );

    assign lvl  = 8'(lvl_n);
    assign rise = 8'(rise_n);

    // Wrapping subtraction makes the hit test independent of BASE_ADDR alignment.
    assign ofs  = PORT_ID - BASE_ADDR;
    assign hit  = ofs < 8'd4;
    assign sel  = ofs[1:0];
    assign wr   = IO_STRB && hit;
    assign pm   = pend_q & mask_q;
    assign win  = prio_enc(pm);
    assign take = (state_q == REQ) && INT_ACK;
    assign eoi  = wr && (sel == OFS_ID);

    // ACK only clears a bit that is genuinely pending and enabled.
    assign ack_clr = take ? (8'(8'd1 << win) & pm) : 8'h00;
    assign w1c     = (wr && sel == OFS_PEND) ? OUT_PORT : 8'h00;

    // New edges are OR-ed in after the clears so a same-cycle set wins.
    assign pend_d  = ((trig & lvl) | (~trig & ((pend_q & ~w1c & ~ack_clr) | rise))) & SRC_MASK;
    assign mask_d  = (wr && sel == OFS_MASK) ? (OUT_PORT & SRC_MASK) : mask_q;
    assign id_d    = take ? win : id_q;

    always_comb
        state_d = (state_q == IDLE) ? ((|pm) ? REQ : IDLE) :
                  (state_q == REQ)  ? (INT_ACK ? SERVICE : ((|pm) ? REQ : IDLE)) :
                                      (eoi ? IDLE : SERVICE);

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            pend_q  <= 8'h00;
            id_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
        end

`ifdef INT_CTRL_LEVEL_TRIG_EN
    logic [7:0] trig_q;

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) trig_q <= 8'h00;
        else if (wr && sel == OFS_TRIG) trig_q <= OUT_PORT & SRC_MASK;

    assign trig = trig_q;
`else
    assign trig = 8'h00;
`endif

    // INT is a decode of the state register, so it is glitch-free and registered.
    assign INT     = (state_q == REQ);
    assign IN_HIT  = hit;
    assign IN_DATA = !hit             ? 8'h00 :
                     (sel == OFS_MASK) ? mask_q :
                     (sel == OFS_PEND) ? pend_q :
                     (sel == OFS_ID)   ? {5'b0, id_q} : trig;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and randomized checks of interrupt_controller against a behavioural model
module tb_interrupt_controller;
    localparam logic [7:0] BASE = 8'h30;
`ifdef INT_CTRL_LEVEL_TRIG_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] IRQ = 8'h00;
    logic       INT_ACK = 1'b0;
    logic [7:0] PORT_ID = BASE;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic       INT;
    logic [7:0] IN_DATA;
    logic       IN_HIT;

    int tests = 0;
    int fails = 0;

    // Model: requesting flag, register images and the IRQ values seen at the last three edges.
    bit [7:0] m_mask, m_pend, m_trig, h1, h2, h3;
    int       m_id;
    bit       m_req, m_svc;

    interrupt_controller #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .INT_ACK(INT_ACK),
        .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
        .INT(INT), .IN_DATA(IN_DATA), .IN_HIT(IN_HIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_mask = 0; m_pend = 0; m_trig = 0; m_id = 0;
        m_req = 0; m_svc = 0; h1 = 0; h2 = 0; h3 = 0;
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] pid);
        logic [7:0] o;
        o = pid - BASE;
        if (o == 0) return m_mask;
        if (o == 1) return m_pend;
        if (o == 2) return 8'(m_id);
        if (o == 3) return LVL ? m_trig : 8'h00;
        return 8'h00;
    endfunction

    task automatic model_edge;
        bit [7:0] pm, clr, edg, o;
        int w;
        bit wr;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        pm = m_pend & m_mask;
        w = -1;
        for (int i = 7; i >= 0; i--) if (pm[i]) w = i;
        o = PORT_ID - BASE;
        wr = IO_STRB && o < 4;
        clr = (wr && o == 1) ? OUT_PORT : 8'h00;
        if (m_req && INT_ACK) begin
            m_id = (w < 0) ? 0 : w;
            if (w >= 0) clr[w] = 1'b1;
        end
        edg = (m_pend & ~clr) | (h2 & ~h3);
        m_pend = (m_trig & h2) | (~m_trig & edg);
        if (m_req) begin
            m_svc = INT_ACK;
            m_req = !INT_ACK && pm != 0;
        end else if (m_svc) begin
            m_svc = !(wr && o == 2);
        end else begin
            m_req = pm != 0;
        end
        if (wr && o == 0) m_mask = OUT_PORT;
        if (LVL && wr && o == 3) m_trig = OUT_PORT;
        h3 = h2; h2 = h1; h1 = IRQ;
    endtask

    task automatic cyc;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("int", 8'(INT), 8'(m_req));
        chk("in_data", IN_DATA, model_rd(PORT_ID));
        chk("in_hit", 8'(IN_HIT), 8'((PORT_ID - BASE) < 8'd4));
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic io_wr(input int off, input logic [7:0] d);
        PORT_ID = BASE + 8'(off); OUT_PORT = d; IO_STRB = 1'b1;
        cyc();
        IO_STRB = 1'b0;
    endtask

    task automatic ack;
        INT_ACK = 1'b1;
        cyc();
        INT_ACK = 1'b0;
    endtask

    task automatic rd(input string tag, input int off, input logic [7:0] exp);
        PORT_ID = BASE + 8'(off);
        #1;
        chk(tag, IN_DATA, exp);
        chk({tag, "_model"}, IN_DATA, model_rd(PORT_ID));
    endtask

    task automatic pulse(input logic [7:0] v);
        IRQ = v;
        cyc();
        IRQ = 8'h00;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset_int", 8'(INT), 8'h00);
        rd("reset_mask", 0, 8'h00);
        rd("reset_pend", 1, 8'h00);
        rd("reset_id", 2, 8'h00);
        rd("reset_rsv", 3, 8'h00);
        RESET_N = 1'b1;
        cyc();

        // 1: single source
        io_wr(0, 8'h04);
        pulse(8'h04);
        cycn(2);
        rd("t1_pend", 1, 8'h04);
        cyc();
        chk("t1_int", 8'(INT), 8'h01);
        ack();
        chk("t1_int_ack", 8'(INT), 8'h00);
        rd("t1_id", 2, 8'h02);
        rd("t1_pend_clr", 1, 8'h00);
        io_wr(2, 8'h00);

        // 2: priority between simultaneous sources
        io_wr(0, 8'hFF);
        pulse(8'h22);
        cycn(3);
        chk("t2_int", 8'(INT), 8'h01);
        ack();
        rd("t2_id", 2, 8'h01);
        rd("t2_pend", 1, 8'h20);
        io_wr(2, 8'h00);
        cyc();
        chk("t2_int_again", 8'(INT), 8'h01);
        ack();
        rd("t2_id2", 2, 8'h05);
        io_wr(2, 8'h00);

        // 3: masking
        io_wr(0, 8'h00);
        pulse(8'h08);
        cycn(4);
        chk("t3_masked", 8'(INT), 8'h00);
        io_wr(0, 8'h08);
        cyc();
        chk("t3_int", 8'(INT), 8'h01);
        io_wr(0, 8'h00);
        cyc();
        chk("t3_drop", 8'(INT), 8'h00);
        io_wr(1, 8'h08);
        rd("t3_w1c", 1, 8'h00);

        // 4: W1C colliding with a new edge
        pulse(8'h01);
        cycn(2);
        rd("t4_pend", 1, 8'h01);
        pulse(8'h01);
        cyc();
        io_wr(1, 8'h01);
        rd("t4_set_wins", 1, 8'h01);

        // 5: edges during SERVICE, stray ACK
        io_wr(0, 8'h01);
        cyc();
        ack();
        rd("t5_id", 2, 8'h00);
        pulse(8'h01);
        cycn(4);
        rd("t5_pend", 1, 8'h01);
        chk("t5_int_held", 8'(INT), 8'h00);
        ack();
        chk("t5_stray_ack", 8'(INT), 8'h00);
        rd("t5_pend2", 1, 8'h01);
        io_wr(2, 8'h00);
        cyc();
        chk("t5_eoi_int", 8'(INT), 8'h01);
        ack();
        io_wr(2, 8'h00);

        // 6: async reset while requesting
        io_wr(0, 8'h02);
        pulse(8'h02);
        cycn(3);
        chk("t6_int", 8'(INT), 8'h01);
        PORT_ID = BASE;
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_int", 8'(INT), 8'h00);
        chk("t6_rst_mask", IN_DATA, 8'h00);
        model_reset();
        cyc();
        RESET_N = 1'b1;
        cyc();

`ifdef INT_CTRL_LEVEL_TRIG_EN
        io_wr(3, 8'h01);
        rd("lvl_trig", 3, 8'h01);
        io_wr(0, 8'h01);
        IRQ = 8'h01;
        cycn(4);
        chk("lvl_int", 8'(INT), 8'h01);
        ack();
        rd("lvl_pend_kept", 1, 8'h01);
        io_wr(2, 8'h00);
        cyc();
        chk("lvl_rereq", 8'(INT), 8'h01);
        IRQ = 8'h00;
        ack();
        cycn(3);
        io_wr(3, 8'h00);
        io_wr(2, 8'h00);
        io_wr(1, 8'hFF);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) IRQ = IRQ ^ (8'd1 << $urandom_range(0, 7));
            PORT_ID  = BASE - 8'd1 + 8'($urandom_range(0, 5));
            OUT_PORT = 8'($urandom);
            IO_STRB  = ($urandom_range(0, 5) == 0);
            INT_ACK  = ($urandom_range(0, 3) == 0);
            cyc();
        end
        IO_STRB = 1'b0;
        INT_ACK = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
